alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Ops 0-6 complete in one cycle; op 7 is a shift-add multiplier that is
// present only when ALU_SEQ_MUL_EN is defined. Without it, op 7 returns
// Result=0 with only the Z flag set.
module alu_seq #(
  parameter int unsigned C_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [C_WIDTH-1:0] A,
  input  logic [C_WIDTH-1:0] B,
  input  logic [2:0]         OpCode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [C_WIDTH-1:0] Result,
  output logic [3:0]         Status,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned AmtW = $clog2(C_WIDTH);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [C_WIDTH-1:0] result_q, result_d;
  logic [3:0]         status_q, status_d;

  // Single-cycle datapath signals
  logic [C_WIDTH:0]   sum;
  logic [C_WIDTH:0]   diff;
  logic [C_WIDTH:0]   shl_ext;
  logic [C_WIDTH:0]   shr_ext;
  logic [AmtW-1:0]    amt;
  logic [C_WIDTH-1:0] alu_res;
  logic               alu_c;
  logic               alu_v;

  assign out_valid = (state_q == StDone);
  // Gated by reset_n so the block never advertises readiness during reset.
  assign in_ready  = reset_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept    = in_valid & in_ready;
  assign Result    = result_q;
  assign Status    = status_q;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CntW = $clog2(C_WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(C_WIDTH);

  logic [2*C_WIDTH-1:0] mcand_q;
  logic [2*C_WIDTH-1:0] acc_q;
  logic [C_WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]      cnt_q;

  assign is_mul   = (OpCode == 3'd7);
  assign mul_done = (state_q == StExec) && (cnt_q == CntMax);

  // Shift-add multiplier: one partial product per EXEC cycle until the counter saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= {{C_WIDTH{1'b0}}, A};
      mplier_q <= B;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if ((state_q == StExec) && (cnt_q != CntMax)) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  // Combinational result and C/V flags for the single-cycle operations.
  always_comb begin
    amt     = B[AmtW-1:0];
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    // One guard bit on each side catches the last bit shifted out.
    shl_ext = {1'b0, A} << amt;
    shr_ext = {A, 1'b0} >> amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (OpCode)
      3'd0: begin
        alu_res = sum[C_WIDTH-1:0];
        alu_c   = sum[C_WIDTH];
        alu_v   = (A[C_WIDTH-1] == B[C_WIDTH-1]) && (sum[C_WIDTH-1] != A[C_WIDTH-1]);
      end
      3'd1: begin
        alu_res = diff[C_WIDTH-1:0];
        alu_c   = diff[C_WIDTH];
        alu_v   = (A[C_WIDTH-1] != B[C_WIDTH-1]) && (diff[C_WIDTH-1] != A[C_WIDTH-1]);
      end
      3'd2: alu_res = A | B;
      3'd3: alu_res = A & B;
      3'd4: alu_res = A ^ B;
      3'd5: begin
        alu_res = shl_ext[C_WIDTH-1:0];
        alu_c   = shl_ext[C_WIDTH];
      end
      3'd6: begin
        alu_res = shr_ext[C_WIDTH:1];
        alu_c   = shr_ext[0];
      end
      3'd7: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // Output register load: single-cycle result on accept, product on multiplier completion.
  always_comb begin
    result_d = result_q;
    status_d = status_q;
    if (accept && !is_mul) begin
      result_d = alu_res;
      status_d = {alu_res[C_WIDTH-1], ~|alu_res, alu_c, alu_v};
    end
`ifdef ALU_SEQ_MUL_EN
    else if (mul_done) begin
      result_d = acc_q[C_WIDTH-1:0];
      status_d = {acc_q[C_WIDTH-1], ~|acc_q[C_WIDTH-1:0], |acc_q[2*C_WIDTH-1:C_WIDTH], 1'b0};
    end
`endif
  end

  // Next-state logic for the IDLE/EXEC/DONE controller.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = is_mul ? StExec : StDone;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      StExec: begin
        if (mul_done) begin
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) begin
          if (accept) begin
            state_d = is_mul ? StExec : StDone;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      status_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (C_WIDTH=8). A driver issues directed and random
// requests and queues the expected response from an arithmetic reference model;
// a monitor checks result, flags, latency, hold behaviour and in_ready.
// Honours ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         in_valid, in_ready;
  logic [W-1:0] result;
  logic [3:0]   status;
  logic         out_valid, out_ready;

  alu_seq #(.C_WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .A         (a),
    .B         (b),
    .OpCode    (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Result    (result),
    .Status    (status),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   st;
    int           acc;
    int           arr;
    bit           mul;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: {N,Z,C,V,result} from integer arithmetic.
  function automatic logic [11:0] model(input int av, input int bv, input int opc);
    int r, c, v, s, amt, sa, sb;
    sa  = (av >= 128) ? av - 256 : av;
    sb  = (bv >= 128) ? bv - 256 : bv;
    amt = bv % 8;
    r = 0; c = 0; v = 0; s = 0;
    case (opc)
      0: begin r = av + bv; c = (r > 255) ? 1 : 0; s = sa + sb; v = (s > 127 || s < -128) ? 1 : 0; end
      1: begin r = av - bv; c = (av < bv) ? 1 : 0; s = sa - sb; v = (s > 127 || s < -128) ? 1 : 0; end
      2: r = av | bv;
      3: r = av & bv;
      4: r = av ^ bv;
      5: begin r = av << amt; c = (amt == 0) ? 0 : ((av >> (8 - amt)) & 1); end
      6: begin r = av >> amt; c = (amt == 0) ? 0 : ((av >> (amt - 1)) & 1); end
`ifdef ALU_SEQ_MUL_EN
      7: begin r = av * bv; c = (r > 255) ? 1 : 0; end
`else
      7: r = 0;
`endif
      default: r = 0;
    endcase
    r = r & 255;
    return {(r >= 128) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, c[0], v[0], r[7:0]};
  endfunction

  // One cycle of stimulus; queues an expectation if the request is taken at the next edge.
  task automatic drive(input bit v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2:0] opc, input bit ordy,
                       input bit k, input logic [W-1:0] kres, input logic [3:0] kst);
    exp_t        e;
    logic [11:0] m;
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = av;
    b         = bv;
    op        = opc;
    out_ready = ordy;
    @(negedge clk);
    if (v && in_ready) begin
      m     = model(int'(av), int'(bv), int'(opc));
      e.res = k ? kres : m[7:0];
      e.st  = k ? kst : m[11:8];
`ifdef ALU_SEQ_MUL_EN
      e.mul = (opc == 3'd7);
`else
      e.mul = 1'b0;
`endif
      e.acc = cyc + 1;
      e.arr = e.acc + (e.mul ? W + 1 : 0);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    out_ready = 1'b0;
    #1;
    chk("reset_result", result, 0);
    chk("reset_status", status, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_first_release", in_ready, 1);

    fork
      // Driver
      begin
        drive(1'b1, 8'h7F, 8'h01, 3'd0, 1'b1, 1'b1, 8'h80, 4'b1001);
        drive(1'b1, 8'h00, 8'h01, 3'd1, 1'b1, 1'b1, 8'hFF, 4'b1010);
        drive(1'b1, 8'h81, 8'h01, 3'd5, 1'b1, 1'b1, 8'h02, 4'b0010);
        idle(2);
`ifdef ALU_SEQ_MUL_EN
        drive(1'b1, 8'd15, 8'd17, 3'd7, 1'b1, 1'b1, 8'hFF, 4'b1000);
        idle(11);
        drive(1'b1, 8'd16, 8'd16, 3'd7, 1'b1, 1'b1, 8'h00, 4'b0110);
        idle(11);
`else
        drive(1'b1, 8'd3, 8'd5, 3'd7, 1'b1, 1'b1, 8'h00, 4'b0100);
        idle(2);
`endif
        // Back-pressure: result held for 3 cycles while new requests are refused.
        drive(1'b1, 8'h05, 8'h06, 3'd0, 1'b1, 1'b1, 8'h0B, 4'b0000);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h11, 8'h22, 3'd0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 8'h02, 4'b0000);
        idle(2);

        // Reset in the middle of an operation.
`ifdef ALU_SEQ_MUL_EN
        drive(1'b1, 8'd15, 8'd17, 3'd7, 1'b1, 1'b0, '0, '0);
        idle(3);
`else
        drive(1'b1, 8'h10, 8'h20, 3'd0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, '0, '0);
`endif
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_result", result, 0);
        chk("async_reset_status", status, 0);
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_in_ready", in_ready, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", in_ready, 1);
        idle(14);
        drive(1'b1, 8'd2, 8'd3, 3'd0, 1'b1, 1'b1, 8'h05, 4'b0000);
        idle(2);

        for (int i = 0; i < 600; i++) begin
          drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                3'($urandom_range(0, 7)), $urandom_range(0, 4) != 0, 1'b0, '0, '0);
        end
        idle(15);
        chk("scoreboard_drained", q.size(), 0);
        done = 1'b1;
      end

      // Monitor
      begin
        bit           holding;
        logic [W-1:0] h_res;
        logic [3:0]   h_st;
        holding = 1'b0;
        h_res   = '0;
        h_st    = '0;
        while (!done) begin
          @(negedge clk);
          if (!reset_n) begin
            q.delete();
            holding = 1'b0;
          end else begin
            if (holding) begin
              chk("hold_out_valid", out_valid, 1);
              chk("hold_result", result, h_res);
              chk("hold_status", status, h_st);
              if (!out_valid) begin
                if (q.size() > 0) void'(q.pop_front());
                holding = 1'b0;
              end
            end else if (q.size() > 0 && cyc == q[0].arr) begin
              chk("out_valid_latency", out_valid, 1);
              if (out_valid) begin
                chk("result", result, q[0].res);
                chk("status", status, q[0].st);
              end else begin
                void'(q.pop_front());
              end
            end else begin
              chk("no_spurious_out_valid", out_valid, 0);
            end

            if (out_valid) begin
              chk("in_ready_done", in_ready, out_ready);
            end else if (q.size() > 0 && q[0].mul && cyc >= q[0].acc && cyc < q[0].arr) begin
              chk("in_ready_exec", in_ready, 0);
            end else if (q.size() == 0 || q[0].acc > cyc) begin
              chk("in_ready_idle", in_ready, 1);
            end

            if (out_valid && q.size() > 0 && (holding || cyc == q[0].arr)) begin
              if (out_ready) begin
                void'(q.pop_front());
                holding = 1'b0;
              end else if (!holding) begin
                holding = 1'b1;
                h_res   = result;
                h_st    = status;
              end
            end
          end
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
